cpa_43_serial: RTL

CPA_43_SERIAL -- requirements
Module: cpa_43_serial

---
 rtl/cpa_43_serial.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cpa_43_serial.sv
// cpa_43_serial
// Chunk-serial carry-propagate adder that folds the sum and carry vectors of
// a 43x43 truncated CSA tree into the final 43-bit truncated product.
// Each ADD cycle adds one CHUNK_W-bit slice of both operands plus the carry
// from the previous slice. A result needs ceil(43/CHUNK_W) cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on B_0/B_1 is valid
//   in_ready   block accepts the operand pair this cycle
//   B_0        43-bit sum vector from the CSA tree
//   B_1        43-bit carry vector from the CSA tree
//   out_valid  P holds a finished result
//   out_ready  consumer takes the result
//   P          (B_0 + B_1) mod 2^43
module cpa_43_serial #(
  parameter int CHUNK_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [42:0] B_0,
  input  logic [42:0] B_1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [42:0] P
);

  localparam int W          = 43;
  localparam int NUM_CHUNKS = (W + CHUNK_W - 1) / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [W-1:0]     CHUNK_ONES = W'((64'd1 << CHUNK_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    HOLD
  } state_e;

  state_e           r_state;
  logic [W-1:0]     r_b0;
  logic [W-1:0]     r_b1;
  logic [W-1:0]     r_p;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_outValid;

  logic [5:0]       w_shift;
  logic [CHUNK_W-1:0] w_aChunk;
  logic [CHUNK_W-1:0] w_bChunk;
  logic [CHUNK_W:0] w_chunkSum;
  logic [W-1:0]     w_mask;
  logic [W-1:0]     w_sumPlaced;
  logic [W-1:0]     w_pNext;
  logic             w_lastChunk;

  // in_ready is combinational on out_ready so a HOLD->ADD handoff can take a
  // new operand pair on the same edge that completes the output transfer.
  always_comb begin
    in_ready = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  end

  // Slice selection: the operands are shifted down so the active chunk sits
  // at bit 0. For the short last chunk the bits above 42 shift in as zero, and
  // the write mask keeps the sum from touching anything outside the chunk.
  always_comb begin
    w_shift     = 6'(r_idx * CHUNK_W);
    w_aChunk    = CHUNK_W'(r_b0 >> w_shift);
    w_bChunk    = CHUNK_W'(r_b1 >> w_shift);
    w_chunkSum  = (CHUNK_W+1)'(w_aChunk) + (CHUNK_W+1)'(w_bChunk)
                + (CHUNK_W+1)'(r_carry);
    w_mask      = CHUNK_ONES << w_shift;
    w_sumPlaced = W'(w_chunkSum[CHUNK_W-1:0]) << w_shift;
    w_pNext     = (r_p & ~w_mask) | (w_sumPlaced & w_mask);
    w_lastChunk = (r_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_b0       <= '0;
      r_b1       <= '0;
      r_p        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_b0    <= B_0;
            r_b1    <= B_1;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_p     <= w_pNext;
          r_carry <= w_chunkSum[CHUNK_W];
          if (w_lastChunk) begin
            // Carry out of bit 42 is dropped: the product is truncated.
            r_outValid <= 1'b1;
            r_state    <= HOLD;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            if (in_valid) begin
              r_b0    <= B_0;
              r_b1    <= B_1;
              r_carry <= 1'b0;
              r_idx   <= '0;
              r_state <= ADD;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign P         = r_p;
  assign out_valid = r_outValid;

endmodule
